mlp_stream_sequencer: RTL and testbench

//  Upstream feeder for the axi_mlp_v1_0 inference core. On start it reads one test image and all layer parameters

---
 rtl/mlp_stream_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mlp_stream_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_sequencer.sv
// mlp_stream_sequencer: reads one image plus all MLP layer parameters from a
// synchronous-read memory and streams them over AXI4-Stream in core order:
// image, {W1 row, B1} per hidden neuron, {W2 row, B2} per output neuron.
module mlp_stream_sequencer #(
    parameter int IMG_LEN  = 784,
    parameter int HID      = 30,
    parameter int OUT      = 10,
    parameter int WORD_W   = 18,
    parameter int TDATA_W  = 32,
    parameter int ADDR_W   = 18,
    parameter int IMG_BASE = 0,
    parameter int W1_BASE  = 78400,
    parameter int B1_BASE  = 101920,
    parameter int W2_BASE  = 101950,
    parameter int B2_BASE  = 102250
) (
    input  logic                   m00_axis_aclk,
    input  logic                   m00_axis_aresetn,
    input  logic                   start,
    input  logic [15:0]            image_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [WORD_W-1:0]      mem_rdata,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic [TDATA_W-1:0]     m00_axis_tdata,
    output logic [TDATA_W/8-1:0]   m00_axis_tstrb,
    output logic                   m00_axis_tlast
);
    localparam int ELEM_W = $clog2(IMG_LEN + 1);
    localparam int NEU_W  = $clog2(HID + OUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_IMG, S_W1, S_B1, S_W2, S_B2, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ELEM_W-1:0]       elem_q, elem_d;
    logic [NEU_W-1:0]        neuron_q, neuron_d;
    logic [15:0]             img_q, img_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    rd_vld_q, rd_last_q, rd_last_d;
    logic [1:0][WORD_W-1:0]  fifo_data_q, fifo_data_d;
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;

    logic       pop, push, head_last, in_rd, last_rd, mem_en_c;
    logic [2:0] occ_after;

    assign pop       = (cnt_q != 2'd0) && m00_axis_tready;
    assign push      = rd_vld_q;
    assign head_last = fifo_last_q[rd_ptr_q];
    assign in_rd     = (state_q == S_IMG) || (state_q == S_W1) || (state_q == S_B1) ||
                       (state_q == S_W2)  || (state_q == S_B2);
    // Slots committed after this edge, not counting a read issued this cycle.
    assign occ_after = {1'b0, cnt_q} + {2'b0, push} - {2'b0, pop};
    assign mem_en_c  = in_rd && (occ_after < 3'd2);

    assign mem_en          = mem_en_c;
    assign busy            = busy_q;
    assign done            = done_q;
    assign m00_axis_tvalid = (cnt_q != 2'd0);
    assign m00_axis_tlast  = m00_axis_tvalid && head_last;
    assign m00_axis_tstrb  = m00_axis_tvalid ? '1 : '0;

    // Read address for the current state/counters; zero outside the read states.
    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_IMG:   mem_addr = ADDR_W'(IMG_BASE + int'(img_q) * IMG_LEN + int'(elem_q));
            S_W1:    mem_addr = ADDR_W'(W1_BASE + int'(neuron_q) * IMG_LEN + int'(elem_q));
            S_B1:    mem_addr = ADDR_W'(B1_BASE + int'(neuron_q));
            S_W2:    mem_addr = ADDR_W'(W2_BASE + int'(neuron_q) * HID + int'(elem_q));
            S_B2:    mem_addr = ADDR_W'(B2_BASE + int'(neuron_q));
            default: mem_addr = '0;
        endcase
    end

    // Zero-extend the FIFO head onto the stream bus.
    always_comb begin
        m00_axis_tdata = '0;
        m00_axis_tdata[WORD_W-1:0] = fifo_data_q[rd_ptr_q];
    end

    // Sequencing FSM: counters only move on cycles that actually issue a read.
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        neuron_d = neuron_q;
        img_d    = img_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IMG, S_W1: last_rd = (elem_q == ELEM_W'(IMG_LEN - 1));
            S_W2:        last_rd = (elem_q == ELEM_W'(HID - 1));
            S_B1, S_B2:  last_rd = 1'b1;
            default:     last_rd = 1'b0;
        endcase
        if (mem_en_c) elem_d = last_rd ? '0 : elem_q + ELEM_W'(1);
        rd_last_d = mem_en_c && (state_q == S_B2) && (neuron_q == NEU_W'(OUT - 1));
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_IMG;
                img_d    = image_idx;
                elem_d   = '0;
                neuron_d = '0;
                busy_d   = 1'b1;
            end
            S_IMG: if (mem_en_c && last_rd) begin
                state_d  = S_W1;
                neuron_d = '0;
            end
            S_W1: if (mem_en_c && last_rd) state_d = S_B1;
            S_B1: if (mem_en_c) begin
                if (neuron_q == NEU_W'(HID - 1)) begin
                    state_d  = S_W2;
                    neuron_d = '0;
                end else begin
                    state_d  = S_W1;
                    neuron_d = neuron_q + NEU_W'(1);
                end
            end
            S_W2: if (mem_en_c && last_rd) state_d = S_B2;
            S_B2: if (mem_en_c) begin
                if (neuron_q == NEU_W'(OUT - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d  = S_W2;
                    neuron_d = neuron_q + NEU_W'(1);
                end
            end
            // Stay in DRAIN through the done cycle so a start there is ignored.
            S_DRAIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (pop && head_last) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry skid FIFO fed by the read returning this cycle.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            neuron_q    <= '0;
            img_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            neuron_q    <= neuron_d;
            img_q       <= img_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_vld_q    <= mem_en_c;
            rd_last_q   <= rd_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mlp_stream_sequencer.sv
// Bench for mlp_stream_sequencer: a full-size instance and a tiny one, both
// backed by a memory whose word[a] = a, so every beat names its own address.
module tb_mlp_stream_sequencer;
    localparam int N  = 784 + 30 * (784 + 1) + 10 * (30 + 1);
    localparam int SN = 4 + 2 * (4 + 1) + 2 * (2 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Address of beat k of a frame, straight from the layout description.
    function automatic int exp_addr(int k, int idx, int L, int H, int O,
                                    int ib, int w1, int b1, int w2, int b2);
        int r, n, e;
        if (k < L) return ib + idx * L + k;
        r = k - L;
        if (r < H * (L + 1)) begin
            n = r / (L + 1); e = r % (L + 1);
            return (e == L) ? b1 + n : w1 + n * L + e;
        end
        r = r - H * (L + 1);
        n = r / (H + 1); e = r % (H + 1);
        if (n >= O) return -1;
        return (e == H) ? b2 + n : w2 + n * H + e;
    endfunction

    // ---------------- full-size instance ----------------
    logic        b_start = 0, b_busy, b_done, b_mem_en, b_tvalid, b_tready = 1, b_tlast;
    logic [15:0] b_idx = 0;
    logic [17:0] b_addr, b_rdata;
    logic [31:0] b_tdata;
    logic [3:0]  b_tstrb;

    mlp_stream_sequencer u_big (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(b_start), .image_idx(b_idx),
        .busy(b_busy), .done(b_done), .mem_en(b_mem_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .m00_axis_tvalid(b_tvalid), .m00_axis_tready(b_tready), .m00_axis_tdata(b_tdata),
        .m00_axis_tstrb(b_tstrb), .m00_axis_tlast(b_tlast));
    always @(posedge clk) if (b_mem_en) b_rdata <= b_addr;

    // ---------------- tiny instance ----------------
    logic        s_start = 0, s_busy, s_done, s_mem_en, s_tvalid, s_tready = 1, s_tlast;
    logic [15:0] s_idx = 0;
    logic [17:0] s_addr, s_rdata;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;

    mlp_stream_sequencer #(.IMG_LEN(4), .HID(2), .OUT(2), .IMG_BASE(0), .W1_BASE(100),
                           .B1_BASE(200), .W2_BASE(300), .B2_BASE(400)) u_sml (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(s_start), .image_idx(s_idx),
        .busy(s_busy), .done(s_done), .mem_en(s_mem_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
        .m00_axis_tvalid(s_tvalid), .m00_axis_tready(s_tready), .m00_axis_tdata(s_tdata),
        .m00_axis_tstrb(s_tstrb), .m00_axis_tlast(s_tlast));
    always @(posedge clk) if (s_mem_en) s_rdata <= s_addr;

    // ---------------- ready drivers ----------------
    bit b_rand = 0;
    initial forever begin
        @(posedge clk); #1;
        b_tready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        s_tready = 1'($urandom_range(0, 1));
    end

    // ---------------- monitors ----------------
    int b_idx_exp = 0, b_t0 = 0, b_beat = 0, b_dones = 0;
    bit b_chk_lat = 0, b_fin = 0, b_stall = 0, b_gotv = 0;
    logic [31:0] b_hold_d; logic b_hold_l;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            b_beat = 0; b_fin = 0; b_stall = 0; b_gotv = 0;
        end else begin
            if (b_stall) begin
                chk("b_hold_tvalid", b_tvalid, 1);
                chk("b_hold_tdata", b_tdata, b_hold_d);
                chk("b_hold_tlast", b_tlast, b_hold_l);
            end
            if (b_fin) begin
                chk("b_done_pulse", b_done, 1);
                chk("b_busy_low_at_done", b_busy, 0);
                if (b_chk_lat) chk("b_done_cycle", cyc, b_t0 + 2 + N);
            end else chk("b_no_spurious_done", b_done, 0);
            b_fin = 0;
            if (b_done) b_dones++;
            chk("b_tstrb", b_tstrb, b_tvalid ? 4'hF : 4'h0);
            if (b_tvalid && !b_gotv) begin
                b_gotv = 1;
                if (b_chk_lat) chk("b_first_tvalid_cycle", cyc, b_t0 + 2);
            end
            if (b_tvalid && b_tready) begin
                chk("b_tdata", b_tdata, 32'(exp_addr(b_beat, b_idx_exp, 784, 30, 10,
                                              0, 78400, 101920, 101950, 102250)));
                chk("b_tlast", b_tlast, b_beat == N - 1);
                if (b_beat == N - 1) begin
                    b_fin = 1; b_gotv = 0;
                    if (b_chk_lat) chk("b_last_beat_cycle", cyc, b_t0 + 2 + N - 1);
                    b_beat = 0;
                end else b_beat++;
            end
            b_stall = b_tvalid && !b_tready; b_hold_d = b_tdata; b_hold_l = b_tlast;
        end
    end

    int s_idx_exp = 0, s_beat = 0, s_dones = 0;
    bit s_fin = 0, s_stall = 0;
    logic [31:0] s_hold_d; logic s_hold_l;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            s_beat = 0; s_fin = 0; s_stall = 0;
        end else begin
            if (s_stall) begin
                chk("s_hold_tvalid", s_tvalid, 1);
                chk("s_hold_tdata", s_tdata, s_hold_d);
                chk("s_hold_tlast", s_tlast, s_hold_l);
            end
            if (s_fin) begin
                chk("s_done_pulse", s_done, 1);
                chk("s_busy_low_at_done", s_busy, 0);
            end else chk("s_no_spurious_done", s_done, 0);
            s_fin = 0;
            if (s_done) s_dones++;
            if (s_tvalid && s_tready) begin
                chk("s_tdata", s_tdata, 32'(exp_addr(s_beat, s_idx_exp, 4, 2, 2,
                                              0, 100, 200, 300, 400)));
                chk("s_tlast", s_tlast, s_beat == SN - 1);
                if (s_beat == SN - 1) begin s_fin = 1; s_beat = 0; end
                else s_beat++;
            end
            s_stall = s_tvalid && !s_tready; s_hold_d = s_tdata; s_hold_l = s_tlast;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic b_go(input int idx);
        @(posedge clk); #1;
        b_start = 1; b_idx = 16'(idx); b_idx_exp = idx; b_t0 = int'(cyc) + 1;
        @(posedge clk); #1;
        b_start = 0;
        chk("b_busy_after_start", b_busy, 1);
    endtask

    task automatic s_go(input int idx);
        @(posedge clk); #1;
        s_start = 1; s_idx = 16'(idx); s_idx_exp = idx;
        @(posedge clk); #1;
        s_start = 0;
        chk("s_busy_after_start", s_busy, 1);
    endtask

    task automatic b_wait_done(input int budget);
        int d0 = b_dones;
        for (int i = 0; i < budget && b_dones == d0; i++) @(posedge clk);
        chk("b_frame_completed", b_dones != d0, 1);
    endtask

    task automatic s_wait_done(input int budget);
        int d0 = s_dones;
        for (int i = 0; i < budget && s_dones == d0; i++) @(posedge clk);
        chk("s_frame_completed", s_dones != d0, 1);
    endtask

    task automatic b_wait_beat(input int k, input int budget);
        int i = 0;
        while (b_beat < k && i < budget) begin @(posedge clk); #1; i++; end
        chk("b_reached_beat", b_beat >= k, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, s0, i;
        bit hit;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {b_busy, s_busy}, 0);
        chk("rst_done", {b_done, s_done}, 0);
        chk("rst_mem_en", {b_mem_en, s_mem_en}, 0);
        chk("rst_tvalid", {b_tvalid, s_tvalid}, 0);
        chk("rst_tlast", {b_tlast, s_tlast}, 0);
        chk("rst_tdata", {b_tdata, s_tdata}, 0);
        chk("rst_tstrb", {b_tstrb, s_tstrb}, 0);
        chk("rst_mem_addr", {b_addr, s_addr}, 0);
        rst_n = 1;
        repeat (2) @(posedge clk);

        // Tiny frames, random backpressure; first one is image 3.
        s0 = s_dones;
        s_go(3); s_wait_done(2000);
        for (int f = 0; f < 3; f++) begin
            s_go(int'($urandom_range(0, 50)));
            s_wait_done(2000);
        end
        // Start during the done cycle must be dropped.
        s_go(9);
        hit = 0;
        for (i = 0; i < 2000 && !hit; i++) begin
            @(posedge clk); #1;
            hit = s_done;
        end
        chk("s_done_seen", hit, 1);
        s_start = 1; s_idx = 7;
        @(posedge clk); #1;
        s_start = 0;
        chk("s_start_in_done_ignored", s_busy, 0);
        @(posedge clk); #1;
        chk("s_idle_after_done_busy", s_busy, 0);
        chk("s_idle_after_done_mem_en", s_mem_en, 0);
        repeat (5) @(posedge clk);
        chk("s_done_count", s_dones - s0, 5);

        // Full frame, tready high, latency checked; re-start at beat 100 ignored.
        d0 = b_dones;
        b_chk_lat = 1; b_rand = 0;
        b_go(0);
        b_wait_beat(100, 400);
        b_start = 1; b_idx = 5;
        @(posedge clk); #1;
        b_start = 0;
        chk("b_busy_after_ignored_start", b_busy, 1);
        b_wait_done(N + 200);
        repeat (20) @(posedge clk);
        #1;
        chk("b_one_done_only", b_dones - d0, 1);
        chk("b_idle_busy", b_busy, 0);
        chk("b_idle_tvalid", b_tvalid, 0);
        b_chk_lat = 0;

        // Reset mid-frame at beat 5000, then a full frame under random backpressure.
        d0 = b_dones;
        b_go(0);
        b_wait_beat(5000, 6000);
        rst_n = 0;
        #1;
        chk("b_abort_tvalid", b_tvalid, 0);
        chk("b_abort_busy", b_busy, 0);
        chk("b_abort_mem_en", b_mem_en, 0);
        chk("b_abort_done", b_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("b_no_done_after_abort", b_dones - d0, 0);
        b_rand = 1;
        b_go(0);
        b_wait_done(4 * N);
        repeat (5) @(posedge clk);
        chk("b_done_after_restart", b_dones - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
